// File: rtl/gate_tt_stimulus_checker_if.sv
// Handshake and result bundle between a sweep controller (master) and the
// gate_tt_stimulus_checker (slave); resp carries the gate-under-test output.
interface gate_tt_stimulus_checker_if #(
    parameter int N_IN  = 2,
    parameter int ERR_W = 4
);
    logic                   start;
    logic                   abort;
    logic [1:0]             op;
    logic [N_IN-1:0]        stim;
    logic                   resp;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [ERR_W-1:0]       err_cnt;
    logic [(1<<N_IN)-1:0]   fail_vec;

    modport master (
        output start, abort, op, resp,
        input  stim, busy, done, pass, err_cnt, fail_vec
    );

    modport slave (
        input  start, abort, op, resp,
        output stim, busy, done, pass, err_cnt, fail_vec
    );
endinterface

// File: rtl/gate_tt_stimulus_checker.sv
// Sweeps every input pattern onto a small combinational gate, waits SETTLE cycles,
// samples the gate output and compares it with the selected reduction function.
module gate_tt_stimulus_checker #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    gate_tt_stimulus_checker_if.slave      bus
);
    localparam int         N_PAT    = 1 << N_IN;
    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_NAND} op_t;

    state_t             r_state;
    op_t                r_op_q;
    logic [3:0]         r_cnt;
    logic [N_IN-1:0]    r_stim;
    logic               r_busy;
    logic               r_done;
    logic [ERR_W-1:0]   r_err_cnt;
    logic [N_PAT-1:0]   r_fail_vec;

    logic               w_exp;
    logic               w_mismatch;
    logic               w_err_sat;
    logic               w_last_pat;

    function automatic logic exp_bit(input op_t op, input logic [N_IN-1:0] s);
        case (op)
            OP_AND:  return &s;
            OP_OR:   return |s;
            OP_XOR:  return ^s;
            default: return ~&s;
        endcase
    endfunction

    assign w_exp      = exp_bit(r_op_q, r_stim);
    assign w_mismatch = (bus.resp != w_exp);
    assign w_err_sat  = &r_err_cnt;
    assign w_last_pat = (r_stim == '1);

    // NOTE: all state updates use <= so every branch sees the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op_q     <= OP_AND;
            r_cnt      <= '0;
            r_stim     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err_cnt  <= '0;
            r_fail_vec <= '0;
        end else if (bus.abort) begin
            // Partial err_cnt/fail_vec are kept for post-mortem inspection.
            r_state <= S_IDLE;
            r_stim  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op_q     <= op_t'(bus.op);
                        r_stim     <= '0;
                        r_cnt      <= SETTLE_C;
                        r_err_cnt  <= '0;
                        r_fail_vec <= '0;
                        r_done     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (w_mismatch) begin
                            r_fail_vec[r_stim] <= 1'b1;
                            if (!w_err_sat) r_err_cnt <= r_err_cnt + 1'b1;
                        end
                        if (w_last_pat) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_stim <= r_stim + 1'b1;
                            r_cnt  <= SETTLE_C;
                        end
                    end
                end
                S_DONE: begin
                    r_stim  <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.stim     = r_stim;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.pass     = r_done && (r_err_cnt == '0);
    assign bus.err_cnt  = r_err_cnt;
    assign bus.fail_vec = r_fail_vec;
endmodule

// File: tb/tb_gate_tt_stimulus_checker.sv
// Scoreboard bench: a truth-table model predicts each sweep's result when start
// is issued; the prediction is popped and compared when done rises.
module tb_gate_tt_stimulus_checker;
    localparam int N_IN   = 2;
    localparam int SETTLE = 2;
    localparam int ERR_W  = 4;
    localparam int SWEEP  = (1 << N_IN) * (SETTLE + 1);

    typedef struct {
        logic [3:0] err;
        logic [3:0] fv;
        logic       pass;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   gut_mode = 0;   // 0: true AND gate, 1: stuck-at-0, 2: stuck-at-1
    int   n_tests  = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    function automatic logic gut_model(input int mode, input logic [1:0] s);
        case (mode)
            0:       return s[0] & s[1];
            1:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic ref_model(input logic [1:0] op, input logic [1:0] s);
        case (op)
            2'b00:   return s[0] & s[1];
            2'b01:   return s[0] | s[1];
            2'b10:   return s[0] ^ s[1];
            default: return ~(s[0] & s[1]);
        endcase
    endfunction

    gate_tt_stimulus_checker_if #(.N_IN(N_IN), .ERR_W(ERR_W)) u_if ();
    gate_tt_stimulus_checker_if #(.N_IN(N_IN), .ERR_W(1))     u_if1 ();

    assign u_if.resp  = gut_model(gut_mode, u_if.stim);
    assign u_if1.resp = 1'b1;

    gate_tt_stimulus_checker #(.N_IN(N_IN), .SETTLE(SETTLE), .ERR_W(ERR_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    gate_tt_stimulus_checker #(.N_IN(N_IN), .SETTLE(SETTLE), .ERR_W(1)) u_dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if1)
    );

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_tests++;
        if ({u_if.stim, u_if.busy, u_if.done, u_if.pass, u_if.err_cnt, u_if.fail_vec} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got stim=%b busy=%b done=%b pass=%b err=%0d fv=%b, expected all 0",
                     u_if.stim, u_if.busy, u_if.done, u_if.pass, u_if.err_cnt, u_if.fail_vec);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        u_if.start = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
    endtask

    // Full sweep through the scoreboard; optional op toggle and start pulse mid-sweep.
    task automatic run_sweep(input string name, input logic [1:0] op_v, input int mode,
                             input bit toggle_op, input bit start_mid);
        exp_t e, got;
        int   cyc;
        int   errs;
        logic [3:0] fv;
        errs = 0;
        fv   = '0;
        for (int p = 0; p < 4; p++) begin
            if (gut_model(mode, 2'(p)) !== ref_model(op_v, 2'(p))) begin
                fv[p] = 1'b1;
                errs++;
            end
        end
        e.err  = 4'(errs);
        e.fv   = fv;
        e.pass = (errs == 0);
        sb_q.push_back(e);

        gut_mode = mode;
        u_if.op  = op_v;
        pulse_start();
        n_tests++;
        if (u_if.busy !== 1'b1 || u_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy: got busy=%b done=%b, expected busy=1 done=0", name, u_if.busy, u_if.done);
        end

        cyc = 0;
        while (u_if.done !== 1'b1 && cyc < 4 * SWEEP) begin
            @(negedge clk);
            cyc++;
            u_if.start = start_mid && (cyc == 5);
            if (toggle_op && cyc == 4) u_if.op = ~op_v;
        end
        u_if.start = 1'b0;
        got = sb_q.pop_front();

        n_tests++;
        if (u_if.done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: done not seen after %0d cycles, expected at %0d", name, cyc, SWEEP);
            return;
        end
        if (cyc != SWEEP) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles, expected %0d", name, cyc, SWEEP);
        end
        n_tests++;
        if (u_if.err_cnt !== got.err || u_if.fail_vec !== got.fv || u_if.pass !== got.pass) begin
            n_fail++;
            $display("FAIL %s_result: got err=%0d fv=%b pass=%b, expected err=%0d fv=%b pass=%b",
                     name, u_if.err_cnt, u_if.fail_vec, u_if.pass, got.err, got.fv, got.pass);
        end

        @(negedge clk);
        n_tests++;
        if (u_if.busy !== 1'b0 || u_if.stim !== 2'b00 || u_if.done !== 1'b1 || u_if.fail_vec !== got.fv) begin
            n_fail++;
            $display("FAIL %s_hold: got busy=%b stim=%b done=%b fv=%b, expected busy=0 stim=00 done=1 fv=%b",
                     name, u_if.busy, u_if.stim, u_if.done, u_if.fail_vec, got.fv);
        end
    endtask

    task automatic test_saturate();
        int cyc;
        @(negedge clk);
        u_if1.start = 1'b1;
        @(negedge clk);
        u_if1.start = 1'b0;
        cyc = 0;
        while (u_if1.done !== 1'b1 && cyc < 4 * SWEEP) begin
            @(negedge clk);
            cyc++;
        end
        n_tests++;
        if (u_if1.done !== 1'b1 || u_if1.err_cnt !== 1'b1 || u_if1.fail_vec !== 4'b0111 || u_if1.pass !== 1'b0) begin
            n_fail++;
            $display("FAIL saturate: got done=%b err=%0d fv=%b pass=%b, expected done=1 err=1 fv=0111 pass=0",
                     u_if1.done, u_if1.err_cnt, u_if1.fail_vec, u_if1.pass);
        end
    endtask

    task automatic test_abort();
        gut_mode = 2;
        u_if.op  = 2'b00;
        pulse_start();
        repeat (4) @(negedge clk);
        u_if.abort = 1'b1;
        @(negedge clk);
        u_if.abort = 1'b0;
        n_tests++;
        if (u_if.busy !== 1'b0 || u_if.stim !== 2'b00 || u_if.done !== 1'b0 ||
            u_if.err_cnt !== 4'd1 || u_if.fail_vec !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort: got busy=%b stim=%b done=%b err=%0d fv=%b, expected busy=0 stim=00 done=0 err=1 fv=0001",
                     u_if.busy, u_if.stim, u_if.done, u_if.err_cnt, u_if.fail_vec);
        end
        repeat (SWEEP + 4) @(negedge clk);
        n_tests++;
        if (u_if.done !== 1'b0 || u_if.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_stays_idle: got done=%b busy=%b, expected 0 0", u_if.done, u_if.busy);
        end
    endtask

    task automatic test_abort_start();
        @(negedge clk);
        u_if.start = 1'b1;
        u_if.abort = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
        u_if.abort = 1'b0;
        n_tests++;
        if (u_if.busy !== 1'b0 || u_if.err_cnt !== 4'd1 || u_if.fail_vec !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_start: got busy=%b err=%0d fv=%b, expected busy=0 err=1 fv=0001",
                     u_if.busy, u_if.err_cnt, u_if.fail_vec);
        end
    endtask

    task automatic test_reset_mid_wait();
        gut_mode = 2;
        u_if.op  = 2'b00;
        pulse_start();
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({u_if.stim, u_if.busy, u_if.done, u_if.pass, u_if.err_cnt, u_if.fail_vec} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_wait: got stim=%b busy=%b done=%b err=%0d fv=%b, expected all 0",
                     u_if.stim, u_if.busy, u_if.done, u_if.err_cnt, u_if.fail_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep("fresh_after_reset", 2'b00, 0, 1'b0, 1'b0);
    endtask

    initial begin
        u_if.start  = 1'b0;
        u_if.abort  = 1'b0;
        u_if.op     = 2'b00;
        u_if1.start = 1'b0;
        u_if1.abort = 1'b0;
        u_if1.op    = 2'b00;

        test_reset();
        run_sweep("and_pass",     2'b00, 0, 1'b0, 1'b0);
        run_sweep("and_stuck0",   2'b00, 1, 1'b0, 1'b0);
        run_sweep("and_stuck1",   2'b00, 2, 1'b0, 1'b0);
        run_sweep("or_toggle_op", 2'b01, 0, 1'b1, 1'b0);
        run_sweep("xor_vs_and",   2'b10, 0, 1'b0, 1'b0);
        run_sweep("nand_vs_and",  2'b11, 0, 1'b0, 1'b0);
        test_saturate();
        run_sweep("start_in_wait", 2'b00, 0, 1'b0, 1'b1);
        test_abort();
        test_abort_start();
        test_reset_mid_wait();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
